// File: rtl/dma_frame_reader.sv
// Memory-to-stream DMA reader: a rising edge on cmd[31] starts a burst of
// word reads from a synchronous RAM port. The words are streamed out through
// a small FIFO to a valid/ready consumer.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a start edge; the command fields are latched here
// READ  | issuing reads while words remain and the FIFO has room
// DRAIN | all reads issued; waiting for the last word to be accepted
// SKIP  | zero-length command; one quiet cycle so done keeps its timing
// FIN   | done pulse for one cycle, then back to IDLE
module dma_frame_reader #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] MEM_LIMIT  = 32'h0004_AFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cmd,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_SKIP,
        S_FIN
    } state_t;

    state_t         state, state_nx;
    logic           start_q;
    logic           armed;
    logic           start_pulse;
    logic [31:0]    ptr, ptr_nx;
    logic [11:0]    remain, remain_nx;
    logic           inflight;
    logic [31:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic [CW:0]    occupancy;
    logic           room;
    logic           push, pop;

    // armed stays low for the first edge after reset, so a start level that
    // is already high when reset releases is only sampled, never acted on.
    assign start_pulse = armed & cmd[31] & ~start_q;

    assign push      = inflight;
    assign pop       = out_valid & out_ready;
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign room      = (occupancy < DEPTH_C);
    assign mem_addr  = !mem_re ? 32'h0 : ((ptr > MEM_LIMIT) ? 32'h0 : ptr);

    // Start-edge detector and the arming flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q <= 1'b0;
            armed   <= 1'b0;
        end else begin
            start_q <= cmd[31];
            armed   <= 1'b1;
        end
    end

    // FSM state, address pointer, word counter and read-in-flight flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            ptr      <= '0;
            remain   <= '0;
            inflight <= 1'b0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            remain   <= remain_nx;
            inflight <= mem_re;
        end
    end

    // Next-state and output decode. DRAIN looks one pop ahead so that done
    // lands in the cycle right after the final word is accepted.
    always_comb begin
        state_nx  = state;
        ptr_nx    = ptr;
        remain_nx = remain;
        mem_re    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_pulse) begin
                    ptr_nx    = {13'b0, cmd[18:2], 2'b00};
                    remain_nx = cmd[30:19];
                    if (cmd[30:19] == 12'd0) begin
                        state_nx = S_SKIP;
                    end else begin
                        state_nx = S_READ;
                    end
                end
            end
            S_READ: begin
                busy = 1'b1;
                if ((remain != 12'd0) && room) begin
                    mem_re    = 1'b1;
                    ptr_nx    = ptr + 32'd4;
                    remain_nx = remain - 12'd1;
                    if (remain == 12'd1) begin
                        state_nx = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (!inflight && ((count == '0) ||
                    ((count == {{(CW-1){1'b0}}, 1'b1}) && pop))) begin
                    state_nx = S_FIN;
                end
            end
            S_SKIP: begin
                state_nx = S_FIN;
            end
            S_FIN: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // FIFO pointers and occupancy count; a simultaneous push and pop leaves
    // the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; unread entries are masked by out_valid, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_rdata;
        end
    end

endmodule
